// File: rtl/ccg_vector_sweeper.sv
// ccg_vector_sweeper: exhaustively sweeps an N_IN-bit stimulus vector into a
// combinational benchmark circuit and compacts every response into a MISR
// signature plus a running count of response 1 bits.
module ccg_vector_sweeper #(
  parameter int               N_IN  = 12,
  parameter int               N_OUT = 18,
  parameter int               SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY  = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED  = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  vec_out,
  input  logic [N_OUT-1:0] resp_in,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic [16:0]      ones_cnt
);

  // Popcount of one response word needs enough bits to hold N_OUT.
  localparam int PC_W  = $clog2(N_OUT + 1);
  // 17 bits hold N_OUT * 2^N_IN = 73728 at the default size.
  localparam int CNT_W = 17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [N_OUT-1:0] resp_q;
  logic             cap_vld;
  logic             last_vec;

  // One MISR shift: shift left, fold in the polynomial on carry-out, then
  // XOR in the zero-extended response word.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic [N_OUT-1:0] r);
    logic [SIG_W-1:0] nxt;
    nxt = {s[SIG_W-2:0], 1'b0};
    if (s[SIG_W-1]) nxt = nxt ^ POLY;
    nxt = nxt ^ SIG_W'(r);
    return nxt;
  endfunction

  function automatic logic [PC_W-1:0] popcount(input logic [N_OUT-1:0] r);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_OUT; i++) c = c + PC_W'(r[i]);
    return c;
  endfunction

  assign last_vec = (vec_out == {N_IN{1'b1}});
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state selection; abort outranks start, start is ignored while busy.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = RUN;
      RUN: begin
        if (abort)         state_nxt = IDLE;
        else if (last_vec) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (abort) state_nxt = IDLE;
        else       state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stimulus counter, response capture and MISR/ones accumulation. The
  // response captured on one edge is compacted on the next, so DRAIN exists
  // only to fold in the final response. An abort drops the pending capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_out   <= '0;
      signature <= '0;
      ones_cnt  <= '0;
      cap_vld   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            vec_out   <= '0;
            signature <= SEED;
            ones_cnt  <= '0;
            cap_vld   <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            cap_vld <= 1'b0;
          end else begin
            resp_q  <= resp_in;
            cap_vld <= 1'b1;
            vec_out <= vec_out + 1'b1;
            if (cap_vld) begin
              signature <= misr_step(signature, resp_q);
              ones_cnt  <= ones_cnt + CNT_W'(popcount(resp_q));
            end
          end
        end
        DRAIN: begin
          if (!abort && cap_vld) begin
            signature <= misr_step(signature, resp_q);
            ones_cnt  <= ones_cnt + CNT_W'(popcount(resp_q));
          end
          cap_vld <= 1'b0;
        end
        default: cap_vld <= 1'b0;
      endcase
    end
  end

endmodule

// File: doc/ccg_vector_sweeper.md
CCG_VECTOR_SWEEPER -- requirements
Module: ccg_vector_sweeper

Interface
REQ-001 SHALL have parameter N_IN, 12, width of the stimulus vector driven to the combinational benchmark circuit.
REQ-002 SHALL have parameter N_OUT, 18, width of the benchmark response vector.
REQ-003 SHALL have parameter SIG_W, 32, MISR signature width.
REQ-004 SHALL have parameter POLY, 32'h04C11DB7, MISR feedback polynomial.
REQ-005 SHALL have parameter SEED, 32'hFFFFFFFF, MISR value loaded on start.
REQ-006 SHALL use one clock and a synchronous, active-high reset.
REQ-007 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-009 SHALL have port start  in  1  sweep request; sampled only in IDLE or DONE.
REQ-010 SHALL have port abort  in  1  terminates a sweep in progress.
REQ-011 SHALL have port vec_out  out  N_IN  stimulus to the circuit; bit i drives input xi.
REQ-012 SHALL have port resp_in  in  N_OUT  circuit response; bit j-1 is output fj, combinational from vec_out.
REQ-013 SHALL have port busy  out  1  high in RUN and DRAIN.
REQ-014 SHALL have port done  out  1  high in DONE.
REQ-015 SHALL have port signature  out  SIG_W  MISR contents.
REQ-016 SHALL have port ones_cnt  out  17  total count of 1 bits over all captured responses.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-018 SHALL move IDLE->RUN or DONE->RUN on start=1 and, on that same edge, clear vec_out to 0, load signature with SEED, clear ones_cnt and the capture-valid flag.
REQ-019 SHALL, on each RUN edge, capture resp_in into resp_q, set capture-valid, and increment vec_out modulo 2^N_IN.
REQ-020 SHALL leave RUN for DRAIN on the edge that captures the response to vec_out = 2^N_IN-1; vec_out wraps to 0 on that edge.
REQ-021 SHALL, on every edge where capture-valid=1, update signature to (signature<<1) XOR (signature[SIG_W-1] ? POLY : 0) XOR zero-extended resp_q, and add popcount(resp_q) to ones_cnt.
REQ-022 SHALL clear capture-valid in DRAIN and move DRAIN->DONE after one cycle, so every one of the 2^N_IN responses enters signature and ones_cnt exactly once.
REQ-023 SHALL give a start-to-done latency of 2^N_IN+1 busy cycles (4097 at default); done rises on the following cycle.
REQ-024 SHALL hold signature, ones_cnt and vec_out stable in DONE and IDLE.
REQ-025 SHALL ignore start while busy=1.
REQ-026 SHALL, on abort=1 in RUN or DRAIN, go to IDLE at the next edge, clear capture-valid, discard the pending resp_q, leave done=0, and retain partial signature/ones_cnt.
REQ-027 SHALL give abort priority over start when both are asserted in the same cycle; abort has no effect in IDLE or DONE.
REQ-028 SHALL size ones_cnt so that N_OUT*2^N_IN (73728 at default) cannot overflow.

Reset
REQ-029 SHALL, on rst=1 at a clock edge in any state including mid-sweep, force IDLE, vec_out=0, busy=0, done=0, signature=0, ones_cnt=0, capture-valid=0.
REQ-030 SHALL give rst priority over start and abort.

Verification
REQ-031 SHALL cover reset: rst held 2 cycles -> busy=0, done=0, vec_out=0, signature=0, ones_cnt=0.
REQ-032 SHALL cover an all-zero response: resp_in=0, start pulse -> busy exactly 4097 cycles, then done=1, ones_cnt=0, signature = SEED clocked 4096 times with zero input (reference model).
REQ-033 SHALL cover an all-ones response: resp_in=18'h3FFFF -> ones_cnt=73728, signature matches the model.
REQ-034 SHALL cover loopback: resp_in={6'b0,vec_out} -> ones_cnt=24576; vec_out sequence 0,1,...,4095 with no gaps or repeats.
REQ-035 SHALL cover abort: abort at RUN cycle 100 -> IDLE next edge, done stays 0, ones_cnt equals the model after 99 or 100 responses per REQ-026; a following start gives a full correct sweep.
REQ-036 SHALL cover start handling: start while busy -> no effect; start in DONE -> new sweep with signature reloaded to SEED; rst at RUN cycle 2000 -> all reset values next cycle.
